wb_arbiter: RTL and testbench
=============================

# wb_arbiter

- Shares the single register-file write port between two sources:
  - the pipeline W stage (ALU/CSR results);
  - late load returns from data memory.
- Late load data is held in a small circular buffer and written when the W stage leaves the port idle.
- The block resolves WAW ordering between late loads and newer W-stage writes, throttles the pipeline before the buffer overflows, and flags load-use hazards to decode.
- It sits between the W stage / data-memory return path and the register file, replacing a plain one-cycle load delay register.

## Interface
- DEPTH, 2: load buffer entries; power of two, ≥2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- RegWE_W  in  1  W-stage write request.
- A4_W  in  5  W-stage destination register.
- Result_W  in  32  W-stage write data.
- LoadValid  in  1  load data returned this cycle.
- LoadRd  in  5  destination of the returned load.
- ReadData  in  32  returned load data.
- Rs1_D, Rs2_D  in  5 each  decode-stage source registers.
- RegWE_WB  out  1  register-file write enable (registered).
- A4_WB  out  5  register-file write address (registered).
- WD_WB  out  32  register-file write data (registered).
- Stall  out  1  pipeline throttle; combinational from occupancy.
- Hazard  out  1  decode source matches a pending load; combinational.
- Overflow  out  1  sticky error flag (registered).

## Operation
- **Requests.**
  - A W-stage request is RegWE_W=1 with A4_W≠0. RegWE_W=1 with A4_W=0 is ignored.
  - A load with LoadRd=0 is discarded.
- **Buffer entries.** Each entry holds {live, rd, data}. Occupancy count is 0..DEPTH and includes killed entries.
- **Port selection, highest priority first:**
  1. W-stage request: write it.
  2. Buffer non-empty: pop the head. A live head is written; a killed head gives RegWE_WB=0 that cycle.
  3. Buffer empty and LoadValid: bypass the load directly to the port.
  4. Otherwise RegWE_WB=0.
- **Enqueue.** LoadValid enqueues at the tail whenever the load is not bypassed.
  - Pop and push in the same cycle leave occupancy unchanged.
- **WAW kill.** A W-stage write with rd=X clears live on every buffered entry with rd=X.
  - If LoadRd=A4_W in the same cycle, the incoming load is dropped: the load is older.
- **Stall.** Stall = (occupancy ≥ DEPTH−1).
  - While Stall=1, upstream presents only bubbles (RegWE_W=0), so the buffer drains one entry per cycle.
- **Overflow.** Set when a load must enqueue at occupancy=DEPTH with no pop that cycle. The load is dropped.
  - Overflow stays 1 until reset.
- **Hazard.** Hazard=1 when a nonzero Rs1_D or Rs2_D equals:
  - the rd of any live buffered entry; or
  - LoadRd while LoadValid=1.
- **Reset (reset=0).**
  - Buffer emptied, pointers and occupancy 0.
  - RegWE_WB=0, A4_WB=0, WD_WB=0, Overflow=0.
  - Hence Stall=0, and Hazard=0 except for a same-cycle LoadValid match.

## Timing
- Register-file outputs have 1-cycle latency: the selection made in cycle N appears on *_WB after edge N+1.
- Worst-case buffered-load latency: occupancy at enqueue + 1 idle W-stage cycle + 1.
- Stall and Hazard respond in the same cycle as the occupancy, buffer or input change.
- Pointers wrap modulo DEPTH.
- Full and empty are distinguished by occupancy, not by pointer equality.
- Reset asserted mid-operation discards all buffered loads, with no writes to the register file.

## Structure
- Package `wb_pkg`:
  - XLEN=32 and REG_AW=5;
  - typedef `wb_req_t` {logic we; logic [4:0] rd; logic [31:0] data};
  - typedef `wb_src_e` {SRC_NONE, SRC_W, SRC_BUF, SRC_BYP}.
- Sub-module `wb_fifo`: circular buffer with push/pop, occupancy, per-entry kill-by-rd and any-match-by-rd ports.
- Top level holds the arbitration, output register, Stall/Hazard logic and the Overflow flag.

## Test plan
- **Bypass.** Idle W, LoadValid with LoadRd=5, ReadData=0xDEADBEEF → next cycle RegWE_WB=1, A4_WB=5, WD_WB=0xDEADBEEF; occupancy stays 0.
- **Collision.**
  - Stimulus: RegWE_W with A4_W=3, Result_W=0x11 and LoadValid with LoadRd=7, ReadData=0x22 in the same cycle, then W idle.
  - Response: writes x3=0x11, then x7=0x22 one cycle later; Hazard=1 for Rs1_D=7 until the pop.
- **WAW kill.**
  - Stimulus: buffer holds rd=9 (0xAA); W writes x9=0xBB.
  - Response: x9=0xBB written; the following idle cycle pops the killed entry with RegWE_WB=0; x9 is never written with 0xAA.
- **Stall and overflow (DEPTH=2).**
  - Two loads enqueued while W is busy → Stall=1 from occupancy 1 onward.
  - A third load at occupancy 2 with W still busy → Overflow=1 and stays 1.
- **x0.** RegWE_W=1 with A4_W=0 and a load to LoadRd=0 → RegWE_WB=0, nothing buffered, Hazard=0 for Rs1_D=0.
- **Reset mid-operation.** reset=0 with 2 entries buffered → outputs zero immediately; after release, idle inputs give no writes.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-port arbiter.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_W,
        SRC_BUF,
        SRC_BYP
    } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back side signals: W-stage request, load return, decode sources, and register-file port.
interface wb_arbiter_if;

    logic                       RegWE_W;
    logic [wb_pkg::REG_AW-1:0]  A4_W;
    logic [wb_pkg::XLEN-1:0]    Result_W;
    logic                       LoadValid;
    logic [wb_pkg::REG_AW-1:0]  LoadRd;
    logic [wb_pkg::XLEN-1:0]    ReadData;
    logic [wb_pkg::REG_AW-1:0]  Rs1_D;
    logic [wb_pkg::REG_AW-1:0]  Rs2_D;
    logic                       RegWE_WB;
    logic [wb_pkg::REG_AW-1:0]  A4_WB;
    logic [wb_pkg::XLEN-1:0]    WD_WB;
    logic                       Stall;
    logic                       Hazard;
    logic                       Overflow;

    modport master (
        output RegWE_W, A4_W, Result_W, LoadValid, LoadRd, ReadData, Rs1_D, Rs2_D,
        input  RegWE_WB, A4_WB, WD_WB, Stall, Hazard, Overflow
    );

    modport slave (
        input  RegWE_W, A4_W, Result_W, LoadValid, LoadRd, ReadData, Rs1_D, Rs2_D,
        output RegWE_WB, A4_WB, WD_WB, Stall, Hazard, Overflow
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Circular buffer of late loads; entries can be killed by rd and searched for live rd matches.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [REG_AW-1:0]            push_rd,
    input  logic [XLEN-1:0]              push_data,
    input  logic                         pop,
    input  logic                         kill_en,
    input  logic [REG_AW-1:0]            kill_rd,
    input  logic [REG_AW-1:0]            match_a,
    input  logic [REG_AW-1:0]            match_b,
    output logic                         head_live,
    output logic [REG_AW-1:0]            head_rd,
    output logic [XLEN-1:0]              head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         hit_a,
    output logic                         hit_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  live;
    logic [REG_AW-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    // Popped slots drop their live bit so the match search never needs the occupancy window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && rd_q[i] == kill_rd) live[i] <= 1'b0;
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + PW'(1);
            end
            if (push) begin
                live[tail] <= 1'b1;
                rd_q[tail] <= push_rd;
                tail       <= tail + PW'(1);
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) data_q[tail] <= push_data;
    end

    assign head_live = live[head];
    assign head_rd   = rd_q[head];
    assign head_data = data_q[head];

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && rd_q[i] == match_a) hit_a = 1'b1;
            if (live[i] && rd_q[i] == match_b) hit_b = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: W stage first, then buffered late loads, then load bypass.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 1);

    logic              w_req;
    logic              load_ok;
    logic              pop;
    logic              push_want;
    logic              push;
    logic              ovf_set;
    logic              head_live;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic [CW-1:0]     count;
    logic              hit_a;
    logic              hit_b;
    logic              overflow_q;
    wb_src_e           src;
    wb_req_t           sel;
    wb_req_t           out_q;

    assign w_req   = bus.RegWE_W && (bus.A4_W != '0);
    // A load racing a W write to the same rd is older, so it must never land.
    assign load_ok = bus.LoadValid && (bus.LoadRd != '0) && !(w_req && bus.LoadRd == bus.A4_W);

    always_comb begin
        src = SRC_NONE;
        if (w_req)              src = SRC_W;
        else if (count != '0)   src = SRC_BUF;
        else if (load_ok)       src = SRC_BYP;
    end

    always_comb begin
        sel = '0;
        unique case (src)
            SRC_W:   sel = '{we: 1'b1, rd: bus.A4_W, data: bus.Result_W};
            SRC_BUF: if (head_live) sel = '{we: 1'b1, rd: head_rd, data: head_data};
            SRC_BYP: sel = '{we: 1'b1, rd: bus.LoadRd, data: bus.ReadData};
            default: sel = '0;
        endcase
    end

    assign pop       = (src == SRC_BUF);
    assign push_want = load_ok && (src != SRC_BYP);
    assign push      = push_want && ((count != FULL) || pop);
    assign ovf_set   = push_want && (count == FULL) && !pop;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (bus.LoadRd),
        .push_data (bus.ReadData),
        .pop       (pop),
        .kill_en   (w_req),
        .kill_rd   (bus.A4_W),
        .match_a   (bus.Rs1_D),
        .match_b   (bus.Rs2_D),
        .head_live (head_live),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (count),
        .hit_a     (hit_a),
        .hit_b     (hit_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q <= sel;
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    assign bus.RegWE_WB = out_q.we;
    assign bus.A4_WB    = out_q.rd;
    assign bus.WD_WB    = out_q.data;
    assign bus.Overflow = overflow_q;
    assign bus.Stall    = (count >= STALL_AT);
    assign bus.Hazard   = ((bus.Rs1_D != '0) && (hit_a || (bus.LoadValid && bus.LoadRd == bus.Rs1_D))) ||
                          ((bus.Rs2_D != '0) && (hit_b || (bus.LoadValid && bus.LoadRd == bus.Rs2_D)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset corner cases, and random traffic vs a queue model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_stall;
        logic        e_haz;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_ovf;
    } vec_t;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    logic        m_ovf;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_stall;
    logic        m_haz;
    logic        d_stall;
    logic        d_haz;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[17];

    function automatic vec_t mk(input logic wwe, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic e_stall, input logic e_haz, input logic e_we,
                                input logic [4:0] e_rd, input logic [31:0] e_wd, input logic e_ovf);
        return '{wwe, wrd, wdata, lv, lrd, ldata, rs1, rs2, e_stall, e_haz, e_we, e_rd, e_wd, e_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic model_hazard(input logic [4:0] rs, input logic lv, input logic [4:0] lrd);
        if (rs == 5'd0) return 1'b0;
        if (lv && lrd == rs) return 1'b1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].live && mq[i].rd == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_idle(input logic [4:0] rs1);
        bus.RegWE_W   = 1'b0;
        bus.A4_W      = '0;
        bus.Result_W  = '0;
        bus.LoadValid = 1'b0;
        bus.LoadRd    = '0;
        bus.ReadData  = '0;
        bus.Rs1_D     = rs1;
        bus.Rs2_D     = '0;
    endtask

    // Drives one cycle, samples Stall/Hazard before the edge, and advances the queue model across it.
    task automatic applyStimulus(input vec_t v);
        bit   wreq;
        bit   bypassed;
        ent_t h;
        ent_t e;
        bus.RegWE_W   = v.wwe;
        bus.A4_W      = v.wrd;
        bus.Result_W  = v.wdata;
        bus.LoadValid = v.lv;
        bus.LoadRd    = v.lrd;
        bus.ReadData  = v.ldata;
        bus.Rs1_D     = v.rs1;
        bus.Rs2_D     = v.rs2;
        #1;
        d_stall = bus.Stall;
        d_haz   = bus.Hazard;
        m_stall = (mq.size() >= DEPTH - 1);
        m_haz   = model_hazard(v.rs1, v.lv, v.lrd) || model_hazard(v.rs2, v.lv, v.lrd);
        @(posedge clk);
        wreq     = v.wwe && (v.wrd != 5'd0);
        bypassed = 1'b0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
        if (wreq) begin
            m_we = 1'b1;
            m_rd = v.wrd;
            m_wd = v.wdata;
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.rd == v.wrd) e.live = 1'b0;
                mq[i] = e;
            end
        end else if (mq.size() != 0) begin
            h = mq.pop_front();
            if (h.live) begin
                m_we = 1'b1;
                m_rd = h.rd;
                m_wd = h.data;
            end
        end else if (v.lv && v.lrd != 5'd0) begin
            m_we = 1'b1;
            m_rd = v.lrd;
            m_wd = v.ldata;
            bypassed = 1'b1;
        end
        if (v.lv && v.lrd != 5'd0 && !bypassed && !(wreq && v.lrd == v.wrd)) begin
            if (mq.size() < DEPTH) mq.push_back('{1'b1, v.lrd, v.ldata});
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic e_stall, input logic e_haz, input logic e_we,
                               input logic [4:0] e_rd, input logic [31:0] e_wd, input logic e_ovf);
        check({tag, ".Stall"},    32'(d_stall),      32'(e_stall));
        check({tag, ".Hazard"},   32'(d_haz),        32'(e_haz));
        check({tag, ".RegWE_WB"}, 32'(bus.RegWE_WB), 32'(e_we));
        if (e_we) begin
            check({tag, ".A4_WB"}, 32'(bus.A4_WB), 32'(e_rd));
            check({tag, ".WD_WB"}, bus.WD_WB,      e_wd);
        end
        check({tag, ".Overflow"}, 32'(bus.Overflow), 32'(e_ovf));
    endtask

    // Asserts reset between edges, expects cleared outputs at once, then releases after one edge.
    task automatic reset_mid(input string tag, input logic [4:0] probe);
        drive_idle(probe);
        reset = 1'b0;
        #1;
        check({tag, ".RegWE_WB"}, 32'(bus.RegWE_WB), 32'd0);
        check({tag, ".A4_WB"},    32'(bus.A4_WB),    32'd0);
        check({tag, ".WD_WB"},    bus.WD_WB,         32'd0);
        check({tag, ".Overflow"}, 32'(bus.Overflow), 32'd0);
        check({tag, ".Stall"},    32'(bus.Stall),    32'd0);
        check({tag, ".Hazard"},   32'(bus.Hazard),   32'd0);
        @(posedge clk);
        #1;
        check({tag, ".held_we"}, 32'(bus.RegWE_WB), 32'd0);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        vec_t v;
        //             wwe  wrd   wdata          lv   lrd    ldata          rs1    rs2   st   hz   we   rd     wd             ovf
        tbl[0]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0);
        tbl[2]  = mk(1'b1, 5'd3, 32'h11,       1'b1, 5'd7,  32'h22,       5'd7,  5'd0, 1'b0, 1'b1, 1'b1, 5'd3,  32'h11,       1'b0);
        tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd0, 1'b1, 1'b1, 1'b1, 5'd7,  32'h22,       1'b0);
        tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0);
        tbl[5]  = mk(1'b1, 5'd1, 32'h01,       1'b1, 5'd9,  32'hAA,       5'd9,  5'd0, 1'b0, 1'b1, 1'b1, 5'd1,  32'h01,       1'b0);
        tbl[6]  = mk(1'b1, 5'd9, 32'hBB,       1'b0, 5'd0,  32'h0,        5'd9,  5'd0, 1'b1, 1'b1, 1'b1, 5'd9,  32'hBB,       1'b0);
        tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0);
        tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0);
        tbl[9]  = mk(1'b1, 5'd2, 32'h02,       1'b1, 5'd10, 32'h10A,      5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 5'd2,  32'h02,       1'b0);
        tbl[10] = mk(1'b1, 5'd4, 32'h04,       1'b1, 5'd11, 32'h10B,      5'd0,  5'd0, 1'b1, 1'b0, 1'b1, 5'd4,  32'h04,       1'b0);
        tbl[11] = mk(1'b1, 5'd6, 32'h06,       1'b1, 5'd12, 32'h10C,      5'd0,  5'd11, 1'b1, 1'b1, 1'b1, 5'd6, 32'h06,       1'b1);
        tbl[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h10A,      1'b1);
        tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h10B,      1'b1);
        tbl[14] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1);
        tbl[15] = mk(1'b1, 5'd0, 32'h55,       1'b1, 5'd0,  32'h66,       5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1);
        tbl[16] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1);

        mq.delete();
        m_ovf = 1'b0;
        drive_idle(5'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.RegWE_WB", 32'(bus.RegWE_WB), 32'd0);
        check("reset.A4_WB",    32'(bus.A4_WB),    32'd0);
        check("reset.WD_WB",    bus.WD_WB,         32'd0);
        check("reset.Overflow", 32'(bus.Overflow), 32'd0);
        check("reset.Stall",    32'(bus.Stall),    32'd0);
        check("reset.Hazard",   32'(bus.Hazard),   32'd0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_haz, tbl[i].e_we,
                        tbl[i].e_rd, tbl[i].e_wd, tbl[i].e_ovf);
        end

        // Two loads parked behind busy W cycles, then reset wipes them without any write.
        applyStimulus(mk(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'h130, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        checkOutput("rst_fill0", m_stall, m_haz, m_we, m_rd, m_wd, m_ovf);
        applyStimulus(mk(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'h140, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        checkOutput("rst_fill1", 1'b1, m_haz, 1'b1, 5'd2, 32'h2, 1'b1);
        reset_mid("rst_mid", 5'd13);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
            checkOutput($sformatf("rst_idle%0d", i), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        end

        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) begin
                reset_mid($sformatf("rnd_rst%0d", n), 5'($urandom_range(0, 7)));
            end
            v = '0;
            v.wwe = ($urandom_range(0, 3) != 0);
            if (mq.size() >= DEPTH - 1 && $urandom_range(0, 7) != 0) v.wwe = 1'b0;
            v.wrd   = 5'($urandom_range(0, 7));
            v.wdata = $urandom;
            v.lv    = 1'($urandom_range(0, 1));
            v.lrd   = 5'($urandom_range(0, 7));
            v.ldata = $urandom;
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            applyStimulus(v);
            checkOutput($sformatf("rnd%0d", n), m_stall, m_haz, m_we, m_rd, m_wd, m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
